rr_mux4: RTL

- Gathering counterpart to the 1-to-4 demultiplexer: merges four WIDTH-bit source channels W, X, Y, Z onto one output stream A.
- Tags each output word with SEL, the 2-bit index of the source channel, so a downstream demultiplexer can route it back out.
- Round-robin arbitration, valid/ready handshakes on all channels, single-entry registered output stage.
- Sits in front of the demultiplexer on a shared 2-bit channel path.

---
 rtl/rr_mux4_pkg.sv | 27 ++
 rtl/rr_mux4_if.sv | 33 +++
 rtl/rr_mux4_arbiter.sv | 34 +++
 rtl/rr_mux4.sv | 90 +++++++++
 4 files changed

// File: rtl/rr_mux4_pkg.sv
// rr_mux4_pkg: constants shared by the 4-to-1 round-robin merger and the
// matching 1-to-4 demultiplexer that decodes its SEL tag.
//   NUM_CH        number of source channels
//   CH_W..CH_Z    SEL codes of channels W, X, Y, Z
//   idx_to_onehot converts a 2-bit channel index into a 4-bit one-hot mask
package rr_mux4_pkg;

    localparam int NUM_CH = 4;

    localparam logic [1:0] CH_W = 2'd0;
    localparam logic [1:0] CH_X = 2'd1;
    localparam logic [1:0] CH_Y = 2'd2;
    localparam logic [1:0] CH_Z = 2'd3;

    function automatic logic [NUM_CH-1:0] idx_to_onehot(input logic [1:0] idx);
        logic [NUM_CH-1:0] mask;
        case (idx)
            CH_W:    mask = 4'b0001;
            CH_X:    mask = 4'b0010;
            CH_Y:    mask = 4'b0100;
            CH_Z:    mask = 4'b1000;
            default: mask = 4'b0000;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/rr_mux4_if.sv
// rr_mux4_if: bundle of the four source channels and the tagged output stream.
//   W, X, Y, Z   source data (channels 0..3)
//   in_valid     per-channel valid, bit i = channel i
//   in_ready     per-channel ready, one-hot or zero
//   A, SEL       output word and its source index
//   out_valid    output word present
//   out_ready    downstream accepts the word
// Modports: slave = merger side, master = sources/sink side.
interface rr_mux4_if #(parameter int WIDTH = 2);
    import rr_mux4_pkg::*;

    logic [WIDTH-1:0]  W;
    logic [WIDTH-1:0]  X;
    logic [WIDTH-1:0]  Y;
    logic [WIDTH-1:0]  Z;
    logic [NUM_CH-1:0] in_valid;
    logic [NUM_CH-1:0] in_ready;
    logic [WIDTH-1:0]  A;
    logic [1:0]        SEL;
    logic              out_valid;
    logic              out_ready;

    modport slave (
        input  W, X, Y, Z, in_valid, out_ready,
        output in_ready, A, SEL, out_valid
    );

    modport master (
        output W, X, Y, Z, in_valid, out_ready,
        input  in_ready, A, SEL, out_valid
    );

endinterface

// File: rtl/rr_mux4_arbiter.sv
// rr_arbiter4: combinational round-robin picker over four requesters.
//   req[3:0]      request vector
//   last[1:0]     index granted most recently
//   gnt_idx[1:0]  first requester found searching from last+1 with wrap
//   gnt_any       at least one request present
module rr_arbiter4
    import rr_mux4_pkg::*;
(
    input  logic [NUM_CH-1:0] req,
    input  logic [1:0]        last,
    output logic [1:0]        gnt_idx,
    output logic              gnt_any
);

    logic [1:0] cand_s;

    // Scan offsets from farthest to nearest so the nearest requester after
    // 'last' is the one left standing; offset 4 wraps back to 'last' itself.
    always_comb begin
        gnt_idx = last;
        gnt_any = 1'b0;
        cand_s  = last;
        for (int k = NUM_CH; k >= 1; k--) begin
            cand_s = last + 2'(k);
            if (req[cand_s]) begin
                gnt_idx = cand_s;
                gnt_any = 1'b1;
            end else begin
                gnt_any = gnt_any;
            end
        end
    end

endmodule

// File: rtl/rr_mux4.sv
// rr_mux4: merges four WIDTH-bit source channels onto one registered output
// stream A, tagging each word with SEL (source index) for a downstream
// demultiplexer. Round-robin arbitration, valid/ready on every channel,
// single-entry output stage giving one word per cycle when out_ready is high.
//   clk   clock, rising edge
//   rst   synchronous active-high reset
//   bus   rr_mux4_if slave: W/X/Y/Z, in_valid, in_ready, A, SEL,
//         out_valid, out_ready
module rr_mux4
    import rr_mux4_pkg::*;
#(
    parameter int WIDTH = 2
)
(
    input  logic      clk,
    input  logic      rst,
    rr_mux4_if.slave  bus
);

    logic [1:0]        last_grant_r;
    logic [WIDTH-1:0]  a_r;
    logic [1:0]        sel_r;
    logic              out_valid_r;

    logic [1:0]        gnt_idx_s;
    logic              gnt_any_s;
    logic              can_load_s;
    logic              xfer_s;
    logic [WIDTH-1:0]  mux_s;
    logic [NUM_CH-1:0] in_ready_s;

    rr_arbiter4 u_arb (
        .req     (bus.in_valid),
        .last    (last_grant_r),
        .gnt_idx (gnt_idx_s),
        .gnt_any (gnt_any_s)
    );

    // Output stage can take a word when empty or being drained this cycle;
    // ready never feeds back on itself, only on valid/out_ready/rst.
    always_comb begin
        can_load_s = ~out_valid_r | bus.out_ready;
        xfer_s     = can_load_s & gnt_any_s & ~rst;
    end

    // Ready goes only to the granted channel, and only when a transfer happens.
    always_comb begin
        if (xfer_s) begin
            in_ready_s = idx_to_onehot(gnt_idx_s);
        end else begin
            in_ready_s = {NUM_CH{1'b0}};
        end
    end

    // Data selection for the granted channel.
    always_comb begin
        case (gnt_idx_s)
            CH_W:    mux_s = bus.W;
            CH_X:    mux_s = bus.X;
            CH_Y:    mux_s = bus.Y;
            CH_Z:    mux_s = bus.Z;
            default: mux_s = {WIDTH{1'b0}};
        endcase
    end

    // Output register and arbitration pointer; reset discards any held word.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_r          <= {WIDTH{1'b0}};
            sel_r        <= CH_W;
            out_valid_r  <= 1'b0;
            last_grant_r <= CH_Z;
        end else if (xfer_s) begin
            a_r          <= mux_s;
            sel_r        <= gnt_idx_s;
            out_valid_r  <= 1'b1;
            last_grant_r <= gnt_idx_s;
        end else if (bus.out_ready) begin
            out_valid_r  <= 1'b0;
        end else begin
            out_valid_r  <= out_valid_r;
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.A         = a_r;
    assign bus.SEL       = sel_r;
    assign bus.out_valid = out_valid_r;

endmodule
